// File: rtl/jtcop_obj_dma_if.sv
// jtcop_obj_dma_if
// Bus bundle between the object DMA controller and its surroundings.
//   obj_copy    CPU write strobe to the *DM register (level, edge detected in the DMA)
//   cpu_obj_cs  CPU owns the object RAM read port this cycle
//   cpu_addr    CPU word address into object RAM
//   ram_addr    object RAM read address (muxed CPU / DMA)
//   ram_dout    object RAM read data, one clock after ram_addr
//   buf_addr    double buffer write address {bank being written, word}
//   buf_din     double buffer write data
//   buf_we      double buffer write enable
//   bank        bank currently shown to the object engine
//   busy        copy in progress (or queued)
//   done        one clock pulse when a copy completes and banks flip
// Modport master is the DMA controller, slave is the environment.
interface jtcop_obj_dma_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          obj_copy;
    logic          cpu_obj_cs;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   buf_addr;
    logic [DW-1:0] buf_din;
    logic          buf_we;
    logic          bank;
    logic          busy;
    logic          done;

    modport master (
        input  obj_copy, cpu_obj_cs, cpu_addr, ram_dout,
        output ram_addr, buf_addr, buf_din, buf_we, bank, busy, done
    );

    modport slave (
        output obj_copy, cpu_obj_cs, cpu_addr, ram_dout,
        input  ram_addr, buf_addr, buf_din, buf_we, bank, busy, done
    );
endinterface

// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma
// Object DMA controller. A rising edge on obj_copy copies the whole object RAM
// (2^AW words) into the inactive bank of a double-buffered object table, then flips
// the bank shown to the object engine. The CPU has absolute priority on the object
// RAM read port; the DMA simply stalls while cpu_obj_cs is high.
// Ports:
//   clk   system clock
//   rstn  synchronous reset, active low
//   bus   jtcop_obj_dma_if.master (request, CPU/RAM read port, buffer write port,
//         bank/busy/done status)
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    jtcop_obj_dma_if.master bus
);

    typedef enum logic [1:0] {IDLE, COPY, FLUSH, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          pending, pending_nx;
    logic          busy, busy_nx;
    logic          bank, bank_nx;
    logic          vld_nx;
    logic          obj_copy_l;
    logic          req;
    logic          issue;

    logic          vld_p1;
    logic [AW-1:0] rd_a_p1;

    assign req   = bus.obj_copy & ~obj_copy_l;
    // A read is issued only when the CPU leaves the port free.
    assign issue = (state == COPY) & ~bus.cpu_obj_cs;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            bank       <= 1'b0;
            vld_p1     <= 1'b0;
            obj_copy_l <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pending    <= pending_nx;
            busy       <= busy_nx;
            bank       <= bank_nx;
            vld_p1     <= vld_nx;
            obj_copy_l <= bus.obj_copy;
        end
    end

    // ---- stage p1: address of the word whose data arrives from RAM this clock
    always_ff @(posedge clk) begin
        if (issue) rd_a_p1 <= cnt;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        busy_nx    = busy;
        bank_nx    = bank;
        vld_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = COPY;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            COPY: begin
                if (req) pending_nx = 1'b1;
                if (issue) begin
                    cnt_nx = cnt + 1'b1;
                    vld_nx = 1'b1;
                    if (cnt == '1) state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (req) pending_nx = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bank_nx = ~bank;
                // A request landing on the DONE clock counts as queued.
                if (pending || req) begin
                    pending_nx = 1'b0;
                    state_nx   = COPY;
                    cnt_nx     = '0;
                end else begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ram_addr = issue ? cnt : bus.cpu_addr;

    // ---- stage p2: buffer write of the word read in p1, always into the hidden bank
    assign bus.buf_we   = vld_p1;
    assign bus.buf_addr = {~bank, rd_a_p1};
    assign bus.buf_din  = bus.ram_dout;

    assign bus.bank = bank;
    assign bus.busy = busy;
    assign bus.done = (state == DONE);

endmodule
